// File: rtl/rv32_run_ctrl_pkg.sv
// Shared encodings and defaults for the RV32 run controller: state codes,
// the EBREAK opcode and default parameter values.
package rv32_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RST  = 3'd2,
        ST_HALT = 3'd3,
        ST_RUN  = 3'd4,
        ST_STEP = 3'd5
    } run_state_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    localparam int DEF_IMEM_AW = 15;
    localparam int DEF_RST_CYC = 4;
    localparam int DEF_CYC_W   = 32;

    function automatic logic is_ebreak(input logic [31:0] insn);
        return (insn == EBREAK_INSN);
    endfunction

endpackage

// File: rtl/rv32_run_ctrl_if.sv
// Host/loader, core-control and imem write signals of the run controller.
// The master side is the host and core model; the slave side is the controller.
interface rv32_run_ctrl_if #(
    parameter int IMEM_AW = rv32_run_pkg::DEF_IMEM_AW,
    parameter int CYC_W   = rv32_run_pkg::DEF_CYC_W
);
    logic               ld_valid;
    logic [7:0]         ld_data;
    logic               ld_last;
    logic               ld_ready;
    logic               run_req;
    logic               step_req;
    logic               stop_req;
    logic [31:0]        instr;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic               cpu_reset;
    logic               cpu_clk_en;
    logic               halt_ebreak;
    logic               load_ovf;
    logic [CYC_W-1:0]   cycles;
    logic [2:0]         state;

    modport master (
        output ld_valid, ld_data, ld_last, run_req, step_req, stop_req, instr,
        input  ld_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, cpu_clk_en,
               halt_ebreak, load_ovf, cycles, state
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, run_req, step_req, stop_req, instr,
        output ld_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, cpu_clk_en,
               halt_ebreak, load_ovf, cycles, state
    );
endinterface

// File: rtl/rv32_run_ctrl_ld_word_packer.sv
// Packs loader bytes LSB-first into 32-bit words, zero-pads a short final
// word and presents one registered imem write per completed word.
module ld_word_packer #(
    parameter int AW = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          accept_i,
    input  logic          restart_i,
    input  logic [7:0]    data_i,
    input  logic          last_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [31:0]   wdata_o,
    output logic          wrap_o
);
    logic [1:0]    idx_q;
    logic [23:0]   bytes_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [31:0]   wdata_q;

    logic [1:0]    idx_eff;
    logic [AW-1:0] addr_eff;
    logic          word_done;
    logic [31:0]   word_d;

    // A restarting load sees byte index and word address as zero in the same cycle.
    always_comb begin
        idx_eff   = idx_q;
        addr_eff  = addr_q;
        word_done = 1'b0;
        word_d    = 32'd0;
        if (restart_i) begin
            idx_eff  = 2'd0;
            addr_eff = '0;
        end else begin
            idx_eff  = idx_q;
            addr_eff = addr_q;
        end
        word_done = accept_i && ((idx_eff == 2'd3) || last_i);
        case (idx_eff)
            2'd0:    word_d = {24'd0, data_i};
            2'd1:    word_d = {16'd0, data_i, bytes_q[7:0]};
            2'd2:    word_d = {8'd0, data_i, bytes_q[15:0]};
            default: word_d = {data_i, bytes_q};
        endcase
    end

    assign wrap_o = word_done && (addr_eff == '1);

    // Byte collection and the registered imem write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= 2'd0;
            bytes_q <= 24'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
        end else begin
            we_q <= word_done;
            if (word_done) begin
                waddr_q <= addr_eff;
                wdata_q <= word_d;
                addr_q  <= addr_eff + AW'(1);
                idx_q   <= 2'd0;
            end else if (accept_i) begin
                case (idx_eff)
                    2'd0:    bytes_q[7:0]   <= data_i;
                    2'd1:    bytes_q[15:8]  <= data_i;
                    default: bytes_q[23:16] <= data_i;
                endcase
                idx_q  <= idx_eff + 2'd1;
                addr_q <= addr_eff;
            end
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
endmodule

// File: rtl/rv32_run_ctrl.sv
// Run controller: loads imem from a byte stream with the core held in reset,
// then gates the core clock enable for run / single-step / stop and EBREAK halt.
module rv32_run_ctrl
    import rv32_run_pkg::*;
#(
    parameter int IMEM_AW = DEF_IMEM_AW,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int CYC_W   = DEF_CYC_W
) (
    input  logic     clock,
    input  logic     reset,
    rv32_run_ctrl_if.slave bus
);
    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    run_state_e       state_q;
    logic             cpu_reset_q;
    logic             ld_ready_q;
    logic             halt_ebreak_q;
    logic             load_ovf_q;
    logic [CYC_W-1:0] cycles_q;
    logic [RCW-1:0]   rst_cnt_q;

    logic             ebreak_now;
    logic             byte_accept;
    logic             load_start;
    logic             clk_en;
    logic             pk_wrap;

    assign ebreak_now  = is_ebreak(bus.instr);
    assign byte_accept = bus.ld_valid && ld_ready_q;
    assign load_start  = byte_accept && (state_q != ST_LOAD);

    // The EBREAK itself is never executed, so it masks the enable.
    always_comb begin
        clk_en = 1'b0;
        if (((state_q == ST_RUN) || (state_q == ST_STEP)) && !ebreak_now) begin
            clk_en = 1'b1;
        end else begin
            clk_en = 1'b0;
        end
    end

    ld_word_packer #(.AW(IMEM_AW)) u_packer (
        .clock     (clock),
        .reset     (reset),
        .accept_i  (byte_accept),
        .restart_i (load_start),
        .data_i    (bus.ld_data),
        .last_i    (bus.ld_last),
        .we_o      (bus.imem_we),
        .waddr_o   (bus.imem_waddr),
        .wdata_o   (bus.imem_wdata),
        .wrap_o    (pk_wrap)
    );

    // Control FSM; every output it drives is registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cpu_reset_q   <= 1'b1;
            ld_ready_q    <= 1'b1;
            halt_ebreak_q <= 1'b0;
            load_ovf_q    <= 1'b0;
            rst_cnt_q     <= '0;
        end else if (byte_accept) begin
            cpu_reset_q <= 1'b1;
            if (pk_wrap) begin
                load_ovf_q <= 1'b1;
            end else if (load_start) begin
                load_ovf_q <= 1'b0;
            end
            if (bus.ld_last) begin
                state_q    <= ST_RST;
                ld_ready_q <= 1'b0;
                rst_cnt_q  <= RCW'(RST_CYC - 1);
            end else begin
                state_q <= ST_LOAD;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    cpu_reset_q <= 1'b1;
                end
                ST_RST: begin
                    if (rst_cnt_q == '0) begin
                        state_q     <= ST_HALT;
                        cpu_reset_q <= 1'b0;
                        ld_ready_q  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RCW'(1);
                    end
                end
                ST_HALT: begin
                    if (bus.run_req) begin
                        state_q    <= ST_RUN;
                        ld_ready_q <= 1'b0;
                    end else if (bus.step_req) begin
                        state_q    <= ST_STEP;
                        ld_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ebreak_now) begin
                        state_q       <= ST_HALT;
                        halt_ebreak_q <= 1'b1;
                        ld_ready_q    <= 1'b1;
                    end else if (bus.stop_req) begin
                        state_q       <= ST_HALT;
                        halt_ebreak_q <= 1'b0;
                        ld_ready_q    <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q       <= ST_HALT;
                    halt_ebreak_q <= ebreak_now;
                    ld_ready_q    <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cpu_reset_q <= 1'b1;
                    ld_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Executed-instruction counter, cleared while the core sits in reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (state_q == ST_RST) begin
            cycles_q <= '0;
        end else if (clk_en && (cycles_q != '1)) begin
            cycles_q <= cycles_q + CYC_W'(1);
        end
    end

    assign bus.ld_ready    = ld_ready_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.cpu_clk_en  = clk_en;
    assign bus.halt_ebreak = halt_ebreak_q;
    assign bus.load_ovf    = load_ovf_q;
    assign bus.cycles      = cycles_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_rv32_run_ctrl.sv
// Bench for rv32_run_ctrl: two instances (IMEM_AW=15 and IMEM_AW=2) in lockstep,
// imem writes checked against scoreboard queues, control outputs checked directly.
module tb_rv32_run_ctrl;
    import rv32_run_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid, ld_last, run_req, step_req, stop_req;
    logic [7:0]  ld_data;
    logic [31:0] instr;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clock = ~clock;

    rv32_run_ctrl_if #(.IMEM_AW(15), .CYC_W(32)) bus0 ();
    rv32_run_ctrl_if #(.IMEM_AW(2),  .CYC_W(32)) bus1 ();

    assign bus0.ld_valid = ld_valid;  assign bus1.ld_valid = ld_valid;
    assign bus0.ld_data  = ld_data;   assign bus1.ld_data  = ld_data;
    assign bus0.ld_last  = ld_last;   assign bus1.ld_last  = ld_last;
    assign bus0.run_req  = run_req;   assign bus1.run_req  = run_req;
    assign bus0.step_req = step_req;  assign bus1.step_req = step_req;
    assign bus0.stop_req = stop_req;  assign bus1.stop_req = stop_req;
    assign bus0.instr    = instr;     assign bus1.instr    = instr;

    rv32_run_ctrl #(.IMEM_AW(15), .RST_CYC(4), .CYC_W(32)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave));
    rv32_run_ctrl #(.IMEM_AW(2),  .RST_CYC(4), .CYC_W(32)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input int unsigned a, input logic [31:0] d);
        q0.push_back({32'(a), d});
        q1.push_back({32'(a % 4), d});
    endtask

    // Scoreboard monitor: every imem write must match the oldest expected write.
    always @(negedge clock) begin
        if (bus0.imem_we === 1'b1) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL wr0_unexpected: got addr %0h data %0h expected no write",
                         bus0.imem_waddr, bus0.imem_wdata);
            end else begin
                chk("wr0", {32'(bus0.imem_waddr), bus0.imem_wdata}, q0.pop_front());
            end
        end
        if (bus1.imem_we === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL wr1_unexpected: got addr %0h data %0h expected no write",
                         bus1.imem_waddr, bus1.imem_wdata);
            end else begin
                chk("wr1", {32'(bus1.imem_waddr), bus1.imem_wdata}, q1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        ld_valid = 1'b1; ld_data = d; ld_last = l;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nb, input logic l);
        for (int i = 0; i < nb; i++) send_byte(w[8*i +: 8], l && (i == nb - 1));
    endtask

    task automatic wait_rst(input string tag);
        int   n = 0;
        logic low = 1'b0;
        chk({tag, "_ld_ready_rst"}, 64'(bus0.ld_ready), 64'd0);
        while (bus0.state == 3'd2 && n < 20) begin
            if (bus0.cpu_reset !== 1'b1) low = 1'b1;
            n++;
            tick();
        end
        chk({tag, "_rst_cycles"}, 64'(n), 64'd4);
        chk({tag, "_reset_held"}, 64'(low), 64'd0);
        chk({tag, "_halt"}, 64'(bus0.state), 64'd3);
        chk({tag, "_halt_aw2"}, 64'(bus1.state), 64'd3);
        chk({tag, "_cpu_reset_low"}, 64'(bus0.cpu_reset), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 64'(bus0.state), 64'd0);
        chk({tag, "_cpu_reset"}, 64'(bus0.cpu_reset), 64'd1);
        chk({tag, "_clk_en"}, 64'(bus0.cpu_clk_en), 64'd0);
        chk({tag, "_we"}, 64'(bus0.imem_we), 64'd0);
        chk({tag, "_waddr"}, 64'(bus0.imem_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(bus0.imem_wdata), 64'd0);
        chk({tag, "_halt_ebreak"}, 64'(bus0.halt_ebreak), 64'd0);
        chk({tag, "_load_ovf"}, 64'(bus1.load_ovf), 64'd0);
        chk({tag, "_cycles"}, 64'(bus0.cycles), 64'd0);
        chk({tag, "_ld_ready"}, 64'(bus0.ld_ready), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_valid = 1'b0; ld_data = 8'd0; ld_last = 1'b0;
        run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
        instr = 32'h0000_0013;
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        tick();

        // Two full words
        exp_wr(0, 32'h0000_0013);
        exp_wr(1, 32'h0010_0093);
        send_word(32'h0000_0013, 4, 1'b0);
        send_word(32'h0010_0093, 4, 1'b1);
        wait_rst("load8");

        // Short final word is zero-padded
        exp_wr(0, 32'h0403_0201);
        exp_wr(1, 32'h0000_00AA);
        send_word(32'h0403_0201, 4, 1'b0);
        send_byte(8'hAA, 1'b1);
        wait_rst("load5");
        chk("load5_ovf", 64'(bus0.load_ovf), 64'd0);

        // Single step, then run+step together, then stop
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("step_state", 64'(bus0.state), 64'd5);
        chk("step_clk_en", 64'(bus0.cpu_clk_en), 64'd1);
        tick();
        chk("step_back_halt", 64'(bus0.state), 64'd3);
        chk("step_clk_en_off", 64'(bus0.cpu_clk_en), 64'd0);
        chk("step_cycles", 64'(bus0.cycles), 64'd1);
        run_req = 1'b1; step_req = 1'b1; tick(); run_req = 1'b0; step_req = 1'b0;
        chk("run_wins", 64'(bus0.state), 64'd4);
        chk("run_clk_en", 64'(bus0.cpu_clk_en), 64'd1);
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        chk("stop_halt", 64'(bus0.state), 64'd3);
        chk("stop_no_ebreak", 64'(bus0.halt_ebreak), 64'd0);
        chk("stop_cycles", 64'(bus0.cycles), 64'd2);

        // Reload clears cycles; run 10 instructions into an EBREAK with stop
        exp_wr(0, 32'h0000_0013);
        send_word(32'h0000_0013, 4, 1'b1);
        wait_rst("reload");
        chk("reload_cycles", 64'(bus0.cycles), 64'd0);
        run_req = 1'b1; tick(); run_req = 1'b0;
        repeat (10) tick();
        instr = EBREAK_INSN; stop_req = 1'b1;
        #1;
        chk("ebreak_clk_en", 64'(bus0.cpu_clk_en), 64'd0);
        chk("ebreak_still_run", 64'(bus0.state), 64'd4);
        tick(); stop_req = 1'b0;
        chk("ebreak_halt", 64'(bus0.state), 64'd3);
        chk("ebreak_flag", 64'(bus0.halt_ebreak), 64'd1);
        chk("ebreak_cycles", 64'(bus0.cycles), 64'd10);
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("step_ebreak_clk_en", 64'(bus0.cpu_clk_en), 64'd0);
        tick();
        chk("step_ebreak_flag", 64'(bus0.halt_ebreak), 64'd1);
        chk("step_ebreak_cycles", 64'(bus0.cycles), 64'd10);
        instr = 32'h0000_0013;
        step_req = 1'b1; tick(); step_req = 1'b0;
        tick();
        chk("step_nop_flag", 64'(bus0.halt_ebreak), 64'd0);
        chk("step_nop_cycles", 64'(bus0.cycles), 64'd11);

        // Five words: the IMEM_AW=2 instance wraps and flags overflow
        for (int i = 0; i < 5; i++) begin
            exp_wr(i, 32'h0101_0101 * (i + 1));
            send_word(32'h0101_0101 * (i + 1), 4, i == 4);
        end
        wait_rst("ovf");
        chk("ovf_aw15", 64'(bus0.load_ovf), 64'd0);
        chk("ovf_aw2", 64'(bus1.load_ovf), 64'd1);
        exp_wr(0, 32'hCAFE_F00D);
        send_byte(8'h0D, 1'b0);
        chk("ovf_cleared", 64'(bus1.load_ovf), 64'd0);
        chk("ovf_new_load", 64'(bus1.state), 64'd1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hCA, 1'b1);
        wait_rst("ovf2");

        // Reset in the middle of a word
        send_byte(8'h55, 1'b0);
        ld_valid = 1'b1; ld_data = 8'h66;
        #2 reset = 1'b1;
        #1;
        chk("abort_load_cpu_reset", 64'(bus0.cpu_reset), 64'd1);
        ld_valid = 1'b0;
        tick(); tick();
        check_reset_vals("abort_load");
        reset = 1'b0;
        tick();

        // Reset during free-run
        exp_wr(0, 32'h0000_0013);
        send_word(32'h0000_0013, 4, 1'b1);
        wait_rst("preload");
        run_req = 1'b1; tick(); run_req = 1'b0;
        repeat (3) tick();
        chk("prerun_state", 64'(bus0.state), 64'd4);
        #2 reset = 1'b1;
        #1;
        chk("abort_run_cpu_reset", 64'(bus0.cpu_reset), 64'd1);
        tick();
        check_reset_vals("abort_run");
        reset = 1'b0;
        tick(); tick();

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
